disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Drives the 3-bit digit select of the 8-to-1 nibble mux that feeds the hex7seg decoder, plus the matching active-low anode enables.
- Inserts a blanking interval between digits to suppress ghosting, supports per-digit enable masking, and emits a once-per-frame tick for upstream display-data update.

Parameters:
- PRESCALE, 50000, clk cycles each digit is lit (SHOW duration); must be >= 1.
- BLANK_CYC, 1000, clk cycles all anodes are off between digits (BLANK duration); must be >= 1.
- CNT_W, 17, width of the internal cycle counter; must hold max(PRESCALE, BLANK_CYC) - 1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low = display dark.
- dig_mask  input  8  per-digit enable; bit i = 1 lights digit i.
- seq_sel  output  3  digit select to the nibble mux, registered.
- anode  output  8  active-low digit enables; bit i drives digit i.
- blank  output  1  high whenever no digit is lit (state != SHOW).
- frame_tick  output  1  one-cycle pulse after seq_sel wraps 7 -> 0, registered.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All flops clear immediately on reset assertion, with no dependence on clk.
- Reset values:
  - state = IDLE, cnt = 0, seq_sel = 3'd0, mask_q = 8'h00.
  - anode = 8'hFF, blank = 1, frame_tick = 0.
- States: IDLE, BLANK, SHOW. State and cnt are registered.
- IDLE: anode = 8'hFF. When en = 1 at a clock edge, go to BLANK with cnt = 0.
- BLANK:
  - Lasts exactly BLANK_CYC cycles (cnt 0 .. BLANK_CYC-1); anode = 8'hFF.
  - On the edge where cnt = BLANK_CYC-1: go to SHOW, cnt = 0, mask_q <= dig_mask.
- SHOW:
  - Lasts exactly PRESCALE cycles (cnt 0 .. PRESCALE-1).
  - anode = ~(onehot(seq_sel) & mask_q), decoded only from registered signals, so glitch-free.
  - On the edge where cnt = PRESCALE-1: seq_sel <= seq_sel + 1 (mod 8), go to BLANK, cnt = 0.
- Digit period: BLANK_CYC + PRESCALE cycles. Frame period: 8 x (BLANK_CYC + PRESCALE) cycles.
- Wrap-around:
  - When seq_sel changes 7 -> 0, frame_tick = 1 for exactly the next cycle, otherwise 0.
  - No frame_tick on the first entry from IDLE.
- Masking:
  - A masked digit keeps its full BLANK + SHOW time slot; anode stays 8'hFF and blank stays 0 during that SHOW.
  - dig_mask changes take effect only at the next BLANK -> SHOW transition.
- en deassert:
  - Sampled every cycle. If en = 0 in BLANK or SHOW, the next state is IDLE, cnt = 0, and anode = 8'hFF from that cycle on.
  - seq_sel is held, not advanced or cleared.
  - Re-enable resumes at the held seq_sel, starting with a full BLANK.
  - en = 0 on the same edge as a SHOW-end takes priority: go to IDLE, and seq_sel is not advanced.
- Reset mid-operation: immediate return to the reset values. At most one anode is ever low at any time, including across reset and en edges.

Test Plan:
Parameters for all scenarios: PRESCALE = 4, BLANK_CYC = 2, CNT_W = 3.
1. Hold reset, then release with en = 1 and dig_mask = 8'hFF.
   -> blank for 2 cycles; anode = 8'hFE with seq_sel = 0 for 4 cycles; blank for 2 cycles; anode = 8'hFD with seq_sel = 1 for 4 cycles; each digit repeats on a 6-cycle period.
2. Run a full frame.
   -> seq_sel steps 0..7. After digit 7's SHOW, seq_sel = 0 and frame_tick is high for exactly 1 cycle. frame_tick repeats every 48 cycles.
3. dig_mask = 8'b0000_0101.
   -> anode goes low only in the slots for seq_sel 0 (8'hFE) and 2 (8'hFB). All other slots keep anode = 8'hFF with unchanged 6-cycle timing.
4. Drop en in the 2nd SHOW cycle of digit 3.
   -> Next cycle: IDLE, anode = 8'hFF, blank = 1, seq_sel stays 3.
   -> Re-assert en: 2 blank cycles, then anode = 8'hF7 for 4 cycles.
5. Change dig_mask from 8'hFF to 8'h00 mid-SHOW of digit 5.
   -> Digit 5 stays lit through its remaining SHOW cycles. Digit 6 onward stays dark.
6. Assert reset asynchronously (between clock edges) mid-SHOW.
   -> anode = 8'hFF, seq_sel = 0, blank = 1, frame_tick = 0 before the next clk edge. Scan restarts normally after release.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - time-multiplexed scan controller for an 8-digit seven-segment display
//
// Walks a 3-bit digit select through digits 0..7. Each digit gets a BLANK
// interval (all anodes off, suppresses ghosting while the nibble mux and
// decoder settle) followed by a SHOW interval (one anode low if that digit
// is enabled in the mask). A one-cycle frame_tick follows every 7 -> 0 wrap.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   scan enable, low forces the display dark
//   dig_mask   in   [7:0] per-digit enable, sampled at each BLANK -> SHOW
//   seq_sel    out  [2:0] registered digit select for the nibble mux
//   anode      out  [7:0] active-low digit enables
//   blank      out  high whenever no digit slot is being shown
//   frame_tick out  one-cycle pulse after seq_sel wraps 7 -> 0

module disp_scan_ctrl #(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 1000,
    parameter int CNT_W     = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] dig_mask,
    output logic [2:0] seq_sel,
    output logic [7:0] anode,
    output logic       blank,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       seq_q, seq_d;
    logic [7:0]       mask_q, mask_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= 3'd0;
            mask_q  <= 8'h00;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            mask_q  <= mask_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        mask_d  = mask_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end

            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    // Mask is captured only here so a digit never changes
                    // brightness partway through its SHOW interval.
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    mask_d  = dig_mask;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SHOW: begin
                // Dropping en wins over the end of SHOW: the digit is not
                // advanced, so re-enabling resumes on the same digit.
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    seq_d   = seq_q + 3'd1;
                    tick_d  = (seq_q == 3'd7);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Anodes are decoded purely from flops, so they cannot glitch and at most
    // one bit can ever be low.
    always_comb begin
        anode = 8'hFF;
        if (state_q == ST_SHOW) begin
            anode = ~((8'd1 << seq_q) & mask_q);
        end
    end

    assign blank      = (state_q != ST_SHOW);
    assign seq_sel    = seq_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl

module tb_disp_scan_ctrl;

    localparam int P = 4;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] dig_mask;
    logic [2:0] seq_sel;
    logic [7:0] anode;
    logic       blank;
    logic       frame_tick;

    disp_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .dig_mask   (dig_mask),
        .seq_sel    (seq_sel),
        .anode      (anode),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time position inside the current digit slot.
    bit         m_dark;
    int         m_t;
    int         m_dig;
    logic [7:0] m_mask;
    bit         m_tick;

    function automatic void model_reset();
        m_dark = 1; m_t = 0; m_dig = 0; m_mask = 8'h00; m_tick = 0;
    endfunction

    function automatic void model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        m_tick = 0;
        if (!en) begin
            m_dark = 1;
        end else if (m_dark) begin
            m_dark = 0;
            m_t    = 0;
        end else begin
            m_t++;
            if (m_t == B) m_mask = dig_mask;
            if (m_t == B + P) begin
                m_t = 0;
                if (m_dig == 7) m_tick = 1;
                m_dig = (m_dig + 1) % 8;
            end
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        bit         show;
        logic [7:0] ea;
        show = !m_dark && (m_t >= B);
        ea   = 8'hFF;
        if (show && m_mask[m_dig]) ea[m_dig] = 1'b0;
        check("model_anode", int'(anode), int'(ea));
        check("model_seq", int'(seq_sel), m_dig);
        check("model_blank", int'(blank), int'(!show));
        check("model_tick", int'(frame_tick), int'(m_tick));
        check("anode_at_most_one_low", int'($countones(~anode) <= 1), 1);
    endtask

    // One clock: model follows the edge, DUT sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset(input logic e, input logic [7:0] m);
        @(negedge clk);
        reset = 1'b1; en = e; dig_mask = m;
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_show(input int d);
        int k;
        for (k = 0; k < 200; k++) begin
            if (!blank && int'(seq_sel) == d) break;
            step();
        end
        check($sformatf("wait_show_%0d_timeout", d), int'(k < 200), 1);
    endtask

    typedef struct {
        logic       en;
        logic [7:0] mask;
        logic [7:0] exp_anode;
        logic [2:0] exp_seq;
        logic       exp_blank;
        logic       exp_tick;
    } vec_t;

    vec_t vecs[15];

    initial begin
        reset = 1'b1; en = 1'b0; dig_mask = 8'h00;
        model_reset();

        // Reset state
        #2;
        check("rst_anode", int'(anode), 8'hFF);
        check("rst_seq", int'(seq_sel), 0);
        check("rst_blank", int'(blank), 1);
        check("rst_tick", int'(frame_tick), 0);

        // Scenario 1: startup cadence, table driven
        vecs[0]  = '{1'b1, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFE, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 8'hFE, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'hFF, 8'hFE, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'hFF, 8'hFE, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'hFF, 8'hFF, 3'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 3'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'hFF, 8'hFD, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'hFF, 8'hFD, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'hFF, 8'hFD, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'hFF, 8'hFD, 3'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'hFF, 8'hFF, 3'd2, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'hFF, 8'hFF, 3'd2, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 8'hFF, 8'hFB, 3'd2, 1'b0, 1'b0};

        do_reset(1'b1, 8'hFF);
        for (int i = 0; i < 15; i++) begin
            en = vecs[i].en; dig_mask = vecs[i].mask;
            step();
            check($sformatf("vec%0d_anode", i), int'(anode), int'(vecs[i].exp_anode));
            check($sformatf("vec%0d_seq", i), int'(seq_sel), int'(vecs[i].exp_seq));
            check($sformatf("vec%0d_blank", i), int'(blank), int'(vecs[i].exp_blank));
            check($sformatf("vec%0d_tick", i), int'(frame_tick), int'(vecs[i].exp_tick));
        end

        // Scenario 2: frame tick every 48 cycles, first one 48 cycles after start
        begin
            int first_tick, last_tick, n_ticks;
            first_tick = -1; last_tick = -1; n_ticks = 0;
            do_reset(1'b1, 8'hFF);
            for (int c = 1; c <= 100; c++) begin
                step();
                if (frame_tick) begin
                    check("tick_seq_zero", int'(seq_sel), 0);
                    if (first_tick < 0) first_tick = c;
                    else check("tick_period", c - last_tick, 48);
                    last_tick = c;
                    n_ticks++;
                end
            end
            check("first_tick_cycle", first_tick, 49);
            check("tick_count", n_ticks, 2);
        end

        // Scenario 3: mask 0000_0101 over one frame
        begin
            int n_fe, n_fb, n_other;
            n_fe = 0; n_fb = 0; n_other = 0;
            do_reset(1'b1, 8'b0000_0101);
            for (int c = 0; c < 48; c++) begin
                step();
                if (anode == 8'hFE) n_fe++;
                else if (anode == 8'hFB) n_fb++;
                else if (anode != 8'hFF) n_other++;
            end
            check("mask_fe_cycles", n_fe, 4);
            check("mask_fb_cycles", n_fb, 4);
            check("mask_other_cycles", n_other, 0);
        end

        // Scenario 4: drop en in the 2nd SHOW cycle of digit 3
        do_reset(1'b1, 8'hFF);
        wait_show(3);
        step();
        en = 1'b0;
        step();
        check("endrop_anode", int'(anode), 8'hFF);
        check("endrop_blank", int'(blank), 1);
        check("endrop_seq", int'(seq_sel), 3);
        step();
        check("endrop_hold_seq", int'(seq_sel), 3);
        en = 1'b1;
        step();
        check("reen_blank0", int'(anode), 8'hFF);
        step();
        check("reen_blank1", int'(anode), 8'hFF);
        for (int c = 0; c < 4; c++) begin
            step();
            check("reen_show_f7", int'(anode), 8'hF7);
        end
        step();
        check("reen_after_show", int'(seq_sel), 4);

        // Scenario 5: mask to 00 mid-SHOW of digit 5
        do_reset(1'b1, 8'hFF);
        wait_show(5);
        step();
        dig_mask = 8'h00;
        step();
        check("mask_mid_show_a", int'(anode), 8'hDF);
        step();
        check("mask_mid_show_b", int'(anode), 8'hDF);
        wait_show(6);
        check("mask_next_dark", int'(anode), 8'hFF);
        check("mask_next_nonblank", int'(blank), 0);

        // Scenario 6: asynchronous reset between clock edges mid-SHOW
        do_reset(1'b1, 8'hFF);
        wait_show(2);
        step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_anode", int'(anode), 8'hFF);
        check("async_rst_seq", int'(seq_sel), 0);
        check("async_rst_blank", int'(blank), 1);
        check("async_rst_tick", int'(frame_tick), 0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) step();

        // Randomized run against the model
        do_reset(1'b1, 8'hFF);
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) == 0) dig_mask = 8'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            if (reset) model_reset();
            step();
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
